// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, logic truth tables and the request payload
// carried through the issue stage of alu_arbiter.
package cpu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD    = 3'b000,
      ALU_ADDC   = 3'b001,
      ALU_SUB    = 3'b010,
      ALU_ROT    = 3'b011,
      ALU_LOGIC  = 3'b100,
      ALU_SELNZ  = 3'b101,
      ALU_SELZ   = 3'b110,
      ALU_SELNEG = 3'b111
   } alu_op_e;

   // Truth tables are indexed by {a_bit, b_bit}
   localparam logic [3:0] LF_AND = 4'b1000;
   localparam logic [3:0] LF_OR  = 4'b1110;
   localparam logic [3:0] LF_XOR = 4'b0110;

   typedef struct packed {
      logic [2:0]  op;
      logic [3:0]  func;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic        id;
   } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two request channels and the response channel of alu_arbiter.
// The arbiter uses the slave modport; requesters/consumer use master.
interface alu_arbiter_if;

   logic        req0_valid;
   logic        req0_ready;
   logic [2:0]  req0_op;
   logic [3:0]  req0_func;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic [15:0] req0_c;

   logic        req1_valid;
   logic        req1_ready;
   logic [2:0]  req1_op;
   logic [3:0]  req1_func;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic [15:0] req1_c;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_data;

   modport master (
      output req0_valid, req0_op, req0_func, req0_a, req0_b, req0_c,
      output req1_valid, req1_op, req1_func, req1_a, req1_b, req1_c,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_op, req0_func, req0_a, req0_b, req0_c,
      input  req1_valid, req1_op, req1_func, req1_a, req1_b, req1_c,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data,
      input  rsp_ready
   );

endinterface

// File: rtl/alu.sv
// Shared 16-bit combinational ALU. Selector ops choose between a+1 (condition on
// inc true) and a+b (condition false); all arithmetic wraps modulo 2^16.
module alu
   import cpu_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [3:0]  i_func,
   input  logic [15:0] i_ina,
   input  logic [15:0] i_inb,
   input  logic [15:0] i_inc,
   output logic [15:0] o_out
);

   logic [15:0] w_sum;
   logic [15:0] w_sum_c;
   logic [15:0] w_inc1;
   logic [15:0] w_diff;
   logic [15:0] w_rot;
   logic [15:0] w_logic;

   assign w_sum   = i_ina + i_inb;
   assign w_sum_c = w_sum + 16'd1;
   assign w_inc1  = i_ina + 16'd1;
   assign w_diff  = i_ina - i_inb;
   // Rotate left by inb[3:0]; a zero amount shifts the wrap term fully out
   assign w_rot   = (i_ina << i_inb[3:0]) | (i_ina >> (5'd16 - {1'b0, i_inb[3:0]}));

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_logic
         assign w_logic[gi] = i_func[{i_ina[gi], i_inb[gi]}];
      end
   endgenerate

   always_comb begin
      o_out = w_sum;
      case (i_op)
         ALU_ADD:    o_out = w_sum;
         ALU_ADDC:   o_out = w_sum_c;
         ALU_SUB:    o_out = w_diff;
         ALU_ROT:    o_out = w_rot;
         ALU_LOGIC:  o_out = w_logic;
         ALU_SELNZ:  o_out = (i_inc != 16'd0) ? w_inc1 : w_sum;
         ALU_SELZ:   o_out = (i_inc == 16'd0) ? w_inc1 : w_sum;
         ALU_SELNEG: o_out = i_inc[15] ? w_inc1 : w_sum;
         default:    o_out = w_sum;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared ALU: two requesters feed an issue stage
// (S1) that drives the ALU, whose output is captured into a response stage (S2).
module alu_arbiter
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);

   alu_req_t    w_req [2];
   logic [1:0]  w_valid;
   logic [1:0]  w_grant;
   logic [1:0]  w_ready;
   logic        w_s2_load;
   logic        w_s1_load;
   logic        w_xfer;
   logic        w_winner;
   logic [15:0] w_alu_out;

   alu_req_t    r_s1;
   logic        r_s1_v;
   logic        r_s2_v;
   logic [15:0] r_s2_data;
   logic        r_s2_id;
   logic        r_last;

   assign w_valid  = {bus.req1_valid, bus.req0_valid};
   assign w_req[0] = '{op: bus.req0_op, func: bus.req0_func, a: bus.req0_a,
                       b: bus.req0_b, c: bus.req0_c, id: 1'b0};
   assign w_req[1] = '{op: bus.req1_op, func: bus.req1_func, a: bus.req1_a,
                       b: bus.req1_b, c: bus.req1_c, id: 1'b1};

   assign w_s2_load = ~r_s2_v | bus.rsp_ready;
   assign w_s1_load = ~r_s1_v | w_s2_load;

   // A requester wins when alone, or when both are valid and it did not win last
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_grant
         assign w_grant[gi] = w_valid[gi] & (~w_valid[1-gi] | (r_last != 1'(gi)));
         assign w_ready[gi] = w_grant[gi] & w_s1_load;
      end
   endgenerate

   assign w_xfer   = |w_ready;
   assign w_winner = w_ready[1];

   assign bus.req0_ready = w_ready[0];
   assign bus.req1_ready = w_ready[1];
   assign bus.rsp_valid  = r_s2_v;
   assign bus.rsp_data   = r_s2_data;
   assign bus.rsp_id     = r_s2_id;

   alu u_alu (
      .i_op   (r_s1.op),
      .i_func (r_s1.func),
      .i_ina  (r_s1.a),
      .i_inb  (r_s1.b),
      .i_inc  (r_s1.c),
      .o_out  (w_alu_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1      <= '0;
         r_s1_v    <= 1'b0;
         r_s2_v    <= 1'b0;
         r_s2_data <= '0;
         r_s2_id   <= 1'b0;
         r_last    <= 1'b1;
      end else begin
         if (w_xfer) begin
            r_s1   <= w_req[w_winner];
            r_s1_v <= 1'b1;
            r_last <= w_winner;
         end else if (w_s1_load) begin
            r_s1_v <= 1'b0;
         end
         if (w_s2_load) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
               r_s2_data <= w_alu_out;
               r_s2_id   <= r_s1.id;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level model (in-flight queue with ages, round-robin winner).
module tb_alu_arbiter;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if bus ();

   alu_arbiter u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic        v  [2];
   logic [2:0]  op [2];
   logic [3:0]  fn [2];
   logic [15:0] pa [2];
   logic [15:0] pb [2];
   logic [15:0] pc [2];
   logic        rrdy;

   assign bus.req0_valid = v[0];
   assign bus.req0_op    = op[0];
   assign bus.req0_func  = fn[0];
   assign bus.req0_a     = pa[0];
   assign bus.req0_b     = pb[0];
   assign bus.req0_c     = pc[0];
   assign bus.req1_valid = v[1];
   assign bus.req1_op    = op[1];
   assign bus.req1_func  = fn[1];
   assign bus.req1_a     = pa[1];
   assign bus.req1_b     = pb[1];
   assign bus.req1_c     = pc[1];
   assign bus.rsp_ready  = rrdy;

   typedef struct {
      logic [15:0] data;
      logic        id;
      int          age;
   } inflight_t;

   inflight_t   pipe [$];
   logic        model_last;
   int          n_vec = 0;
   int          n_miss = 0;
   int          n_obs_acc0 = 0;
   int          n_obs_rsp = 0;
   logic [15:0] rsp_seen_data;
   logic        got_xfer;
   logic        got_id;

   function automatic logic [15:0] ref_alu(logic [2:0] o, logic [3:0] f,
                                           logic [15:0] a, logic [15:0] b, logic [15:0] c);
      logic [31:0] w;
      logic [15:0] r;
      case (o)
         ALU_ADD:    r = a + b;
         ALU_ADDC:   r = a + b + 16'd1;
         ALU_SUB:    r = a - b;
         ALU_ROT:    begin w = {a, a} << (b % 16); r = w[31:16]; end
         ALU_LOGIC:  r = ({16{f[3]}} & a & b) | ({16{f[2]}} & a & ~b)
                       | ({16{f[1]}} & ~a & b) | ({16{f[0]}} & ~a & ~b);
         ALU_SELNZ:  r = (c != 0) ? a + 16'd1 : a + b;
         ALU_SELZ:   r = (c == 0) ? a + 16'd1 : a + b;
         default:    r = ($signed(c) < 0) ? a + 16'd1 : a + b;
      endcase
      return r;
   endfunction

   task automatic chk1(string tag, logic obs, logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(string tag, int obs, int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at the falling edge, then advance the model at the rising edge
   task automatic step();
      logic acc, win, e_r0, e_r1, e_rv;
      @(negedge clk);
      acc  = !(pipe.size() == 2 && !rrdy);
      win  = (v[0] && v[1]) ? ~model_last : v[1];
      e_r0 = acc && v[0] && !win;
      e_r1 = acc && v[1] && win;
      e_rv = (pipe.size() > 0) && (pipe[0].age >= 1);
      chk1("req0_ready", bus.req0_ready, e_r0);
      chk1("req1_ready", bus.req1_ready, e_r1);
      chk1("rsp_valid", bus.rsp_valid, e_rv);
      if (e_rv) begin
         chk16("rsp_data", bus.rsp_data, pipe[0].data);
         chk1("rsp_id", bus.rsp_id, pipe[0].id);
      end
      if (bus.req0_ready === 1'b1) n_obs_acc0++;
      if (bus.rsp_valid === 1'b1 && rrdy) begin
         rsp_seen_data = bus.rsp_data;
         n_obs_rsp++;
      end
      @(posedge clk);
      if (e_rv && rrdy) void'(pipe.pop_front());
      for (int i = 0; i < pipe.size(); i++) pipe[i].age++;
      got_xfer = e_r0 || e_r1;
      got_id   = win;
      if (got_xfer) begin
         pipe.push_back('{ref_alu(op[win], fn[win], pa[win], pb[win], pc[win]), win, 0});
         model_last = win;
      end
      #1;
   endtask

   task automatic single(logic [2:0] o, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                         logic [15:0] spec_y, string tag);
      op[0] = o; fn[0] = LF_AND; pa[0] = a; pb[0] = b; pc[0] = c;
      v[0] = 1'b1; rrdy = 1'b1; rsp_seen_data = 16'hDEAD;
      step();
      v[0] = 1'b0;
      step();
      step();
      chk16(tag, rsp_seen_data, spec_y);
   endtask

   task automatic randomize_req(int r);
      op[r] = 3'($urandom_range(0, 7));
      fn[r] = 4'($urandom);
      pa[r] = 16'($urandom);
      pb[r] = 16'($urandom);
      pc[r] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc_before, rsp_before, prev_id;
      for (int r = 0; r < 2; r++) begin
         v[r] = 1'b0; op[r] = '0; fn[r] = '0; pa[r] = '0; pb[r] = '0; pc[r] = '0;
      end
      rrdy = 1'b1;
      model_last = 1'b1;
      got_xfer = 1'b0;
      got_id = 1'b0;
      rsp_seen_data = '0;

      // Reset state: stages empty, readies follow the valids
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk16("rst_rsp_data", bus.rsp_data, 16'h0000);
      chk1("rst_rsp_id", bus.rsp_id, 1'b0);
      v[0] = 1'b1; #1;
      chk1("rst_ready0", bus.req0_ready, 1'b1);
      chk1("rst_ready1_idle", bus.req1_ready, 1'b0);
      v[0] = 1'b0; v[1] = 1'b1; #1;
      chk1("rst_ready1", bus.req1_ready, 1'b1);
      chk1("rst_ready0_idle", bus.req0_ready, 1'b0);
      v[1] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // First op: 3 + 4 from requester 0, visible two edges after acceptance
      single(ALU_ADD, 16'h0003, 16'h0004, 16'h0000, 16'h0007, "add_3_4");

      // Both requesters streaming: grants must alternate
      op[0] = ALU_SUB;   fn[0] = '0;     pa[0] = 16'h0000; pb[0] = 16'h0001; pc[0] = '0;
      op[1] = ALU_LOGIC; fn[1] = LF_XOR; pa[1] = 16'hFF00; pb[1] = 16'h0FF0; pc[1] = '0;
      v[0] = 1'b1; v[1] = 1'b1; rrdy = 1'b1;
      step();
      prev_id = int'(got_id);
      for (int k = 0; k < 7; k++) begin
         step();
         chk_int("grant_alternates", int'(got_id), 1 - prev_id);
         prev_id = int'(got_id);
      end
      v[0] = 1'b0; v[1] = 1'b0;
      repeat (2) step();

      // Backpressure: only two ops accepted while the consumer stalls
      acc_before = n_obs_acc0;
      rrdy = 1'b0;
      op[0] = ALU_ADD; pa[0] = 16'h0100; pb[0] = 16'h0001; pc[0] = '0;
      v[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         if (got_xfer) pa[0] = pa[0] + 16'h0100;
      end
      chk_int("stall_accepts", n_obs_acc0 - acc_before, 2);
      v[0] = 1'b0; rrdy = 1'b1;
      rsp_before = n_obs_rsp;
      for (int k = 0; k < 10 && pipe.size() > 0; k++) step();
      step();
      chk_int("stall_drain_count", n_obs_rsp - rsp_before, 2);

      // Selector, rotate and wrap cases
      single(ALU_SELNZ,  16'h0010, 16'h0100, 16'h0000, 16'h0110, "selnz_c0");
      single(ALU_SELZ,   16'h0010, 16'h0100, 16'h0000, 16'h0011, "selz_c0");
      single(ALU_SELNEG, 16'h0010, 16'h0100, 16'h8000, 16'h0011, "selneg_c8000");
      single(ALU_ROT,    16'h8001, 16'h0001, 16'h0000, 16'h0003, "rot_8001");
      single(ALU_ADDC,   16'hFFFF, 16'h0000, 16'h0000, 16'h0000, "addc_wrap");

      // Random traffic with random consumer backpressure
      for (int k = 0; k < 400; k++) begin
         for (int r = 0; r < 2; r++) begin
            if (!v[r] && $urandom_range(0, 1) == 1) begin
               randomize_req(r);
               v[r] = 1'b1;
            end
         end
         rrdy = ($urandom_range(0, 3) != 0);
         step();
         if (got_xfer) v[got_id] = 1'b0;
      end
      v[0] = 1'b0; v[1] = 1'b0; rrdy = 1'b1;
      for (int k = 0; k < 10 && pipe.size() > 0; k++) step();

      // Asynchronous reset with two ops in flight
      rrdy = 1'b0;
      op[0] = ALU_ADD; pa[0] = 16'h1111; pb[0] = 16'h2222; pc[0] = '0;
      v[0] = 1'b1;
      step();
      step();
      v[0] = 1'b0;
      chk_int("inflight_before_reset", pipe.size(), 2);
      chk1("rsp_valid_before_reset", bus.rsp_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk1("rsp_valid_async_drop", bus.rsp_valid, 1'b0);
      pipe.delete();
      model_last = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rrdy = 1'b1;
      op[1] = ALU_ADD; fn[1] = '0; pa[1] = 16'h0001; pb[1] = 16'h0002; pc[1] = '0;
      v[1] = 1'b1;
      step();
      chk1("post_reset_req1_first", got_id, 1'b1);
      v[0] = 1'b1;
      step();
      if (got_xfer) v[got_id] = 1'b0;
      step();
      if (got_xfer) v[got_id] = 1'b0;
      v[0] = 1'b0; v[1] = 1'b0;
      for (int k = 0; k < 10 && pipe.size() > 0; k++) step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared 16-bit ALU. It arbitrates between the execute stage (requester 0) and the address/auxiliary unit (requester 1) with round-robin fairness, registers the granted operation into an issue stage that drives the ALU, and captures the result into a response register with valid/ready backpressure. It contains the only `alu` instance in the CPU core; no other block drives ALU ports.

## Interface
Parameters:
- none; all widths are fixed by the ALU: data 16, op 3, logic_func 4.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid` / `req1_valid`  in  1  requester has an operation
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle
- `req0_op` / `req1_op`  in  3  ALU opcode
- `req0_func` / `req1_func`  in  4  logic truth table, used for op 100
- `req0_a` / `req1_a`, `req0_b` / `req1_b`, `req0_c` / `req1_c`  in  16 each  operands ina, inb, inc
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `rsp_id`  out  1  requester that issued the result
- `rsp_data`  out  16  ALU result

## Operation
- Transfer rules:
  - Request transfer occurs when `reqN_valid & reqN_ready` is high at a clock edge.
  - Response transfer occurs when `rsp_valid & rsp_ready` is high at a clock edge.
- State:
  - Issue stage S1: `s1_v`, op, func, a, b, c, id.
  - Result stage S2: `s2_v`, data, id.
  - Round-robin pointer `last`, 1 bit.
- Advance conditions:
  - `s2_load = !s2_v | rsp_ready`
  - `s1_load = !s1_v | s2_load`
- Grant:
  - Only one valid requester: that requester wins.
  - Both valid: the requester != `last` wins.
  - `reqN_ready = grantN & s1_load`. Ready is combinational from valids, `s1_v`, `s2_v` and `rsp_ready`.
  - `last` updates to the winner only on a request transfer.
- S1 fields load on a request transfer. `s1_v` clears when S1 advances with no new grant.
- S1 drives the ALU combinationally. On `s2_load & s1_v`, S2 captures the ALU output and id.
- `rsp_valid = s2_v`, `rsp_data = s2 data`, `rsp_id = s2 id`.
- Operands and opcode are passed unmodified; ALU arithmetic wraps modulo 2^16.
- Requesters must hold valid and payload stable until ready. The block does not check this.

## Timing
- Reset values:
  - `s1_v = 0`, `s2_v = 0`, `last = 1`, so requester 0 wins first.
  - Outputs: `rsp_valid = 0`, `rsp_data = 0`, `rsp_id = 0`, `req0_ready` and `req1_ready` follow their valids, since both stages are empty.
- Latency: request transferred at edge N gives `rsp_valid = 1` after edge N+1, so the result is consumable at edge N+2.
- Throughput: one operation per cycle while `rsp_ready = 1`.
- Backpressure:
  - With `rsp_ready = 0`, S2 holds, then S1 holds, and both readies drop.
  - At most 2 operations are in flight.
- Simultaneous events: with `s2_v = 1`, `rsp_ready = 1` and `s1_v = 1`, S2 is replaced by the new result in the same edge with no bubble.
- Reset mid-operation: in-flight operations are discarded with no response, and `last` returns to 1.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants `ALU_ADD = 000`, `ALU_ADDC = 001`, `ALU_SUB = 010`, `ALU_ROT = 011`, `ALU_LOGIC = 100`, `ALU_SELNZ = 101`, `ALU_SELZ = 110`, `ALU_SELNEG = 111`
  - logic truth-table constants `LF_AND = 1000`, `LF_OR = 1110`, `LF_XOR = 0110`
- One sub-module: the existing `alu`, instantiated unchanged between S1 and S2.
- Arbitration and pipeline registers live in this module.

## Test plan
- Reset, then `req0`: op 000, a = 0x0003, b = 0x0004. Result: `req0_ready = 1`; `rsp_valid`, `rsp_id = 0`, `rsp_data = 0x0007` two edges later.
- Both requesters valid every cycle with `rsp_ready = 1`. req0 sends op 010 with a = 0x0000, b = 0x0001; req1 sends op 100 LF_XOR with a = 0xFF00, b = 0x0FF0. Result: grants alternate 0,1,0,1; responses alternate 0xFFFF and 0xF0F0.
- `rsp_ready = 0` for 5 cycles while req0 streams. Result: exactly 2 operations accepted, both readies low afterwards, no result lost or duplicated after release.
- Selector ops, all with a = 0x0010, b = 0x0100: op 101 with c = 0 gives 0x0110; op 110 with c = 0 gives 0x0011; op 111 with c = 0x8000 gives 0x0011.
- Op 011 with a = 0x8001, b = 0x0001 gives 0x0003. Op 001 with a = 0xFFFF, b = 0x0000 gives 0x0000 (wrap).
- Assert `rst_n` low asynchronously with 2 operations in flight. Result: `rsp_valid` drops immediately with no clock edge, and after release req1 alone is granted first when req0 is idle.
